// File: rtl/joybus_pkg.sv
// Shared definitions for the N64 joybus link controller: FSM encodings,
// command opcodes and the response length (in bits) of each command.
package joybus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE_RX    = 3'd0,
    ST_DECODE     = 3'd1,
    ST_TURNAROUND = 3'd2,
    ST_TX_ACTIVE  = 3'd3,
    ST_RECOVER    = 3'd4
  } joybus_state_e;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [8:0] LEN_INFO   = 9'd24;
  localparam logic [8:0] LEN_STATUS = 9'd32;
  localparam logic [8:0] LEN_READ   = 9'd264;
  localparam logic [8:0] LEN_WRITE  = 9'd8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/joybus_cmd_decode.sv
// Maps a joybus command byte to its response length; known=0 for any
// opcode the controller does not answer.
module joybus_cmd_decode
  import joybus_pkg::*;
(
  input  logic [7:0] cmd,
  output logic       known,
  output logic [8:0] len
);

  always_comb begin
    known = 1'b1;
    len   = '0;
    case (cmd)
      CMD_INFO, CMD_RESET: len = LEN_INFO;
      CMD_STATUS:          len = LEN_STATUS;
      CMD_READ:            len = LEN_READ;
      CMD_WRITE:           len = LEN_WRITE;
      default:             known = 1'b0;
    endcase
  end

endmodule

// File: rtl/n64_joybus_link_ctrl.sv
// Half-duplex joybus line arbiter: accepts a received command, waits the
// turnaround gap, hands the line to the transmitter and recovers from errors.
module n64_joybus_link_ctrl
  import joybus_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 16,
  parameter int TX_TIMEOUT_CYCLES = 4096,
  parameter int RECOVER_CYCLES    = 32
) (
  input  logic          sample_clk,
  input  logic          reset_n,
  input  logic          rx_cmd_valid,
  input  logic [7:0]    rx_cmd,
  input  logic          rx_error,
  input  logic          tx_done_toggle,
  output logic          cur_operation,
  output logic [7:0]    tx_cmd,
  output logic [8:0]    tx_len,
  output logic          busy,
  output logic [7:0]    cmd_count,
  output logic [7:0]    err_count,
  output joybus_state_e dbg_state
);

  // Handshake: rx_cmd_valid and rx_error are single-cycle pulses with no
  // back-pressure; a pulse that arrives while the FSM cannot use it is lost.

  localparam int TIMER_W = $clog2(max3(TURNAROUND_CYCLES, TX_TIMEOUT_CYCLES,
                                       RECOVER_CYCLES)) + 1;
  localparam logic [TIMER_W-1:0] TA_LOAD = TIMER_W'(TURNAROUND_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD = TIMER_W'(TX_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RC_LOAD = TIMER_W'(RECOVER_CYCLES - 1);

  joybus_state_e        state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           tx_cmd_q, tx_cmd_d;
  logic [8:0]           tx_len_q, tx_len_d;
  logic [7:0]           cmd_count_q, cmd_count_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 toggle_q;
  logic                 done_edge;
  logic                 latch_cmd;
  logic                 accept_cmd;
  logic                 count_err;
  logic                 dec_known;
  logic [8:0]           dec_len;

  joybus_cmd_decode u_cmd_decode (
    .cmd   (tx_cmd_q),
    .known (dec_known),
    .len   (dec_len)
  );

  assign done_edge = tx_done_toggle ^ toggle_q;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE_RX;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // One down-counter serves every timed state; it is reloaded on entry and
  // the state is left on the cycle it reads zero.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    latch_cmd  = 1'b0;
    accept_cmd = 1'b0;
    count_err  = 1'b0;
    case (state_q)
      ST_IDLE_RX: begin
        if (rx_error) begin
          state_d   = ST_RECOVER;
          timer_d   = RC_LOAD;
          count_err = 1'b1;
        end else if (rx_cmd_valid) begin
          state_d   = ST_DECODE;
          latch_cmd = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_known) begin
          state_d    = ST_TURNAROUND;
          timer_d    = TA_LOAD;
          accept_cmd = 1'b1;
        end else begin
          state_d = ST_IDLE_RX;
        end
      end
      ST_TURNAROUND: begin
        if (timer_q == '0) begin
          state_d = ST_TX_ACTIVE;
          timer_d = TO_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_TX_ACTIVE: begin
        if (done_edge) begin
          state_d = ST_IDLE_RX;
        end else if (timer_q == '0) begin
          state_d   = ST_RECOVER;
          timer_d   = RC_LOAD;
          count_err = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_RECOVER: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE_RX;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE_RX;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    tx_cmd_d    = latch_cmd  ? rx_cmd  : tx_cmd_q;
    tx_len_d    = accept_cmd ? dec_len : tx_len_q;
    cmd_count_d = accept_cmd ? cmd_count_q + 8'd1 : cmd_count_q;
    err_count_d = (count_err && (err_count_q != 8'hFF)) ? err_count_q + 8'd1
                                                         : err_count_q;
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cmd_q    <= '0;
      tx_len_q    <= '0;
      cmd_count_q <= '0;
      err_count_q <= '0;
      toggle_q    <= 1'b0;
    end else begin
      tx_cmd_q    <= tx_cmd_d;
      tx_len_q    <= tx_len_d;
      cmd_count_q <= cmd_count_d;
      err_count_q <= err_count_d;
      toggle_q    <= tx_done_toggle;
    end
  end

  // Line ownership decodes straight from the state register so that an
  // asynchronous reset releases the line without waiting for a clock.
  always_comb begin
    cur_operation = (state_q == ST_TX_ACTIVE);
    busy          = (state_q != ST_IDLE_RX);
    dbg_state     = state_q;
  end

  assign tx_cmd    = tx_cmd_q;
  assign tx_len    = tx_len_q;
  assign cmd_count = cmd_count_q;
  assign err_count = err_count_q;

endmodule

// File: doc/n64_joybus_link_ctrl.md
N64_JOYBUS_LINK_CTRL -- requirements
Module: n64_joybus_link_ctrl

Interface
REQ-001 SHALL have parameter TURNAROUND_CYCLES, default 16, sample_clk cycles between command stop bit and start of response.
REQ-002 SHALL have parameter TX_TIMEOUT_CYCLES, default 4096, maximum cycles allowed in TX_ACTIVE before forced recovery.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 32, quiet-line cycles held after an error or timeout.
REQ-004 sample_clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rx_cmd_valid  input  1  one-cycle pulse: receiver has a complete command byte including stop bit.
REQ-007 rx_cmd  input  8  command byte; valid only when rx_cmd_valid=1.
REQ-008 rx_error  input  1  one-cycle pulse: receiver framing error.
REQ-009 tx_done_toggle  input  1  toggles once per completed transmitter response, including stop bit.
REQ-010 cur_operation  output  1  0 = receiver owns the line, 1 = transmitter owns the line.
REQ-011 tx_cmd  output  8  latched command handed to the transmitter.
REQ-012 tx_len  output  9  response length in bits.
REQ-013 busy  output  1  high in every state except IDLE_RX.
REQ-014 cmd_count  output  8  number of accepted commands; wraps modulo 256.
REQ-015 err_count  output  8  number of framing errors plus timeouts; saturates at 255.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE_RX, DECODE, TURNAROUND, TX_ACTIVE, RECOVER.
REQ-017 IDLE_RX + rx_cmd_valid SHALL latch rx_cmd into tx_cmd and move to DECODE on the next cycle.
REQ-018 DECODE SHALL last one cycle and set tx_len: 0x00/0xFF -> 24, 0x01 -> 32, 0x02 -> 264, 0x03 -> 8.
REQ-019 For any other command, DECODE SHALL return to IDLE_RX, leave cmd_count unchanged and leave tx_len unchanged.
REQ-020 For a recognised command, DECODE SHALL increment cmd_count and move to TURNAROUND.
REQ-021 TURNAROUND SHALL count TURNAROUND_CYCLES cycles with cur_operation=0, then enter TX_ACTIVE.
REQ-022 On entry to TX_ACTIVE, cur_operation SHALL rise exactly TURNAROUND_CYCLES+2 cycles after the rx_cmd_valid pulse.
REQ-023 The block SHALL register tx_done_toggle and detect an edge as a change between the input and its registered value.
REQ-024 An edge SHALL be honoured only in TX_ACTIVE and SHALL return the FSM to IDLE_RX, with cur_operation=0 on the next cycle.
REQ-025 Edges in any other state SHALL only update the registered value.
REQ-026 If TX_ACTIVE reaches TX_TIMEOUT_CYCLES cycles with no edge, the FSM SHALL enter RECOVER, drop cur_operation and increment err_count.
REQ-027 rx_error in IDLE_RX SHALL enter RECOVER and increment err_count.
REQ-028 rx_error in any other state SHALL be ignored.
REQ-029 RECOVER SHALL hold cur_operation=0 for RECOVER_CYCLES cycles, ignore rx_cmd_valid, then return to IDLE_RX.
REQ-030 If rx_cmd_valid and rx_error arrive in the same IDLE_RX cycle, rx_error SHALL win: no latch, err_count+1, enter RECOVER.
REQ-031 rx_cmd_valid outside IDLE_RX SHALL be dropped; cmd_count SHALL be unchanged.
REQ-032 A timeout and an edge on the same cycle SHALL be treated as an edge: IDLE_RX, no error counted.
REQ-033 A single shared down-counter SHALL time TURNAROUND, TX_ACTIVE and RECOVER, reloading on each state entry; its width SHALL be clog2 of the largest parameter plus 1.

Reset
REQ-034 Assertion of reset_n=0 SHALL, asynchronously: state=IDLE_RX, cur_operation=0, tx_cmd=0x00, tx_len=0, busy=0, cmd_count=0, err_count=0, timer=0.
REQ-035 On reset the registered toggle SHALL be loaded with 0; a tx_done_toggle of 1 after release SHALL produce one ignored edge.
REQ-036 Reset mid-TX_ACTIVE SHALL drop cur_operation immediately, without waiting for a clock edge.

Structure
REQ-037 A shared package (joybus_pkg) SHALL hold: the state encodings; command constants CMD_INFO=0x00, CMD_STATUS=0x01, CMD_READ=0x02, CMD_WRITE=0x03, CMD_RESET=0xFF; and the response lengths 24/32/264/8.
REQ-038 Command-to-length decode SHALL be one combinational sub-module, joybus_cmd_decode, with outputs known and len[8:0].

Verification
REQ-039 rx_cmd_valid with 0x01 at cycle 0 -> tx_len=32, cmd_count=1, cur_operation=1 at cycle 18 (default parameters).
REQ-040 rx_cmd=0x02; toggle tx_done_toggle 300 cycles later -> tx_len=264, cur_operation=0 on the next cycle, busy=0.
REQ-041 rx_cmd=0x7A -> busy high for exactly one cycle, cmd_count unchanged, cur_operation stays 0.
REQ-042 rx_cmd=0x00 with no done toggle -> cur_operation falls 4096 cycles after rising, err_count=1, busy for a further 32 cycles.
REQ-043 rx_cmd_valid and rx_error in the same cycle -> err_count=1, cmd_count=0, a command issued during RECOVER is ignored.
REQ-044 reset_n pulled low mid-TX_ACTIVE -> all outputs at reset values before the next sample_clk edge; cmd_count=0.
